mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Serialises the two issue slots of a dual-issue bundle onto the single data-memory port.
//  Lets the scheduler issue up to two loads/stores per bundle.
//  Sits between the MEM stage's slot-select logic and DataMemory.
//  Holds the pipeline via stall_req until each access has completed on a ready/valid memory handshake.
//  Has a wait-cycle watchdog.
// PARAMETERS
//  DATA_W         32   data and address width
//  TIMEOUT_CYCLES 255  max cycles in an ACC state without mem_ready before the access is aborted
// PORTS
//  clk           in  1       clock
//  rst           in  1       reset; synchronous, active-low (0 = reset)
//  bundle_valid  in  1       bundle present; held stable while stall_req=1
//  flush         in  1       kill current bundle
//  stall_ext     in  1       downstream stall; holds DONE
//  reqN_valid    in  1       slot N (N=0,1) valid
//  reqN_read     in  1       slot N load
//  reqN_write    in  1       slot N store
//  reqN_width    in  2       slot N access width
//  reqN_unsigned in  1       slot N zero-extend load
//  reqN_addr     in  DATA_W  slot N address
//  reqN_wdata    in  DATA_W  slot N store data
//  reqN_pc       in  32      slot N PC
//  mem_req       out 1       access request
//  mem_re        out 1       read enable
//  mem_we        out 1       write enable
//  mem_width     out 2       access width to memory
//  mem_unsigned  out 1       zero-extend flag to memory
//  mem_addr      out DATA_W  address to memory
//  mem_wdata     out DATA_W  store data to memory
//  mem_pc        out 32      PC of slot being served
//  mem_is_inst1  out 1       slot 1 is being served
//  mem_ready     in  1       access completes this cycle
//  mem_rdata     in  DATA_W  load data; valid with mem_ready
//  rdata0        out DATA_W  registered load result, slot 0
//  rdata1        out DATA_W  registered load result, slot 1
//  done          out 1       bundle accesses complete
//  stall_req     out 1       hold the pipeline
//  timeout_err   out 1       sticky watchdog flag
// BEHAVIOUR
//  needN = reqN_valid & (reqN_read | reqN_write); needs_any = need0 | need1.
//  States: IDLE, ACC0, ACC1, DONE (2-bit enum).
//  Reset (rst=0 at posedge): state=IDLE, wait_cnt=0, rdata0=rdata1=0, timeout_err=0.
//    All combinational outputs then evaluate to 0; any in-flight access is abandoned.
//  IDLE
//    bundle_valid & !flush & need0 -> ACC0
//    else bundle_valid & !flush & need1 -> ACC1
//    bundle_valid & !needs_any -> done=1 combinationally, no stall, stay IDLE.
//  ACC0 / ACC1
//    mem_req=1; memory fields driven from the served slot.
//    mem_re=read, mem_we=write; mem_is_inst1=(state==ACC1).
//    On mem_ready: capture rdataN = read ? mem_rdata : 0.
//    On mem_ready, from ACC0: go to ACC1 if need1 & !flush, else DONE.
//    On mem_ready, from ACC1: go to DONE.
//  Exactly one memory commit per slot: mem_we is only ever high in that slot's ACC state.
//    The state is left on the ready cycle.
//  flush in ACC0/ACC1: the access in flight completes (no abort).
//    It then goes to IDLE (not DONE), slot 1 is not started, and rdata is not updated.
//  wait_cnt: clears on ACC entry; increments each ACC cycle with mem_ready=0.
//    At wait_cnt==TIMEOUT_CYCLES-1 with no ready: abort the access, rdataN=0, timeout_err<=1, go to DONE.
//    timeout_err is cleared only by reset.
//  DONE: done=1, stall_req=0; rdata0/rdata1 stable.
//    Stays while stall_ext=1; goes to IDLE when stall_ext=0 (or on flush).
//  stall_req = (IDLE & bundle_valid & needs_any & !flush) | ACC0 | ACC1.
//  Latency, zero-wait memory: 1 access -> 2 stall cycles; 2 accesses -> 3 stall cycles.
//  mem_ready outside ACC states is ignored.
// STRUCTURE
//  MipsDefinitions.sv (shared package):
//    mem_arb_state_t enum
//    mem_req_t struct {valid, read, write, width, unsigned, addr, wdata, pc}
//    MEM_ARB_TIMEOUT_DEFAULT constant
//  Sub-module mem_wait_timer: clear/enable/expire counter, width $clog2(TIMEOUT_CYCLES+1).
//  Top level: FSM + slot mux + rdata registers.
// TESTING
//  1 Bundle, no memory ops: done=1 same cycle, stall_req=0, mem_req never high.
//  2 Slot0 load addr 0x100, mem_ready=1 with rdata 0xCAFE0001:
//    stall_req for 2 cycles; rdata0=0xCAFE0001, rdata1=0; done in cycle 3.
//  3 Slot0 store 0x10 + slot1 load 0x14, zero-wait memory:
//    exactly one mem_we pulse (slot0, mem_is_inst1=0), then mem_re with mem_is_inst1=1; 3 stall cycles.
//  4 Same as 3, flush during ACC0 with ready delayed 2 cycles:
//    store completes once, ACC1 is never entered, return to IDLE, done never asserted.
//  5 mem_ready held 0 with TIMEOUT_CYCLES=4:
//    abort after 4 ACC cycles, timeout_err=1 sticky, rdata0=0, DONE entered.
//  6 rst=0 while in ACC1: next cycle state=IDLE, mem_req=0, stall_req=0, rdata0=rdata1=0, timeout_err=0.
//  7 stall_ext=1 in DONE for 3 cycles: rdata held, done=1 throughout, IDLE after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the dual-slot data-memory port arbiter.
// Imported by the arbiter top and its wait timer.
package mem_port_arbiter_pkg;

  localparam int MEM_ARB_TIMEOUT_DEFAULT = 255;
  localparam int MEM_ARB_DATA_W          = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_DONE = 2'd3
  } mem_arb_state_t;

  typedef struct packed {
    logic                      valid;
    logic                      read;
    logic                      write;
    logic [1:0]                width;
    logic                      is_unsigned;
    logic [MEM_ARB_DATA_W-1:0] addr;
    logic [MEM_ARB_DATA_W-1:0] wdata;
    logic [31:0]               pc;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Wait-cycle counter for one memory access.
// o_expire flags the last cycle allowed before an abort.
module mem_wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises two issue-slot loads/stores onto one data-memory port,
// stalling the pipeline until each access has completed.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W         = MEM_ARB_DATA_W,
  parameter int TIMEOUT_CYCLES = MEM_ARB_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bundle_valid,
  input  logic              flush,
  input  logic              stall_ext,
  input  logic              req0_valid,
  input  logic              req0_read,
  input  logic              req0_write,
  input  logic [1:0]        req0_width,
  input  logic              req0_unsigned,
  input  logic [DATA_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [31:0]       req0_pc,
  input  logic              req1_valid,
  input  logic              req1_read,
  input  logic              req1_write,
  input  logic [1:0]        req1_width,
  input  logic              req1_unsigned,
  input  logic [DATA_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [31:0]       req1_pc,
  output logic              mem_req,
  output logic              mem_re,
  output logic              mem_we,
  output logic [1:0]        mem_width,
  output logic              mem_unsigned,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [31:0]       mem_pc,
  output logic              mem_is_inst1,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              done,
  output logic              stall_req,
  output logic              timeout_err
);

  mem_arb_state_t r_state, w_nxt;

  mem_req_t w_s0, w_s1, w_cur;

  logic              r_flushed;
  logic              r_timeout;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_need0, w_need1, w_need_any;
  logic              w_in_acc, w_kill, w_expire;
  logic              w_commit, w_abort;
  logic              w_wr0, w_wr1;
  logic [DATA_W-1:0] w_load_val, w_new_val;
  logic              w_unused_valid;

  assign w_s0 = {req0_valid, req0_read, req0_write, req0_width,
                 req0_unsigned, req0_addr, req0_wdata, req0_pc};
  assign w_s1 = {req1_valid, req1_read, req1_write, req1_width,
                 req1_unsigned, req1_addr, req1_wdata, req1_pc};

  assign w_cur          = (r_state == ST_ACC1) ? w_s1 : w_s0;
  assign w_unused_valid = w_cur.valid;

  assign w_need0    = w_s0.valid & (w_s0.read | w_s0.write);
  assign w_need1    = w_s1.valid & (w_s1.read | w_s1.write);
  assign w_need_any = w_need0 | w_need1;

  assign w_in_acc = (r_state == ST_ACC0) | (r_state == ST_ACC1);

  // A flush seen at any point of an access kills the bundle at completion.
  assign w_kill   = flush | r_flushed;
  assign w_commit = w_in_acc & mem_ready & ~w_kill;
  assign w_abort  = w_in_acc & ~mem_ready & w_expire;

  assign w_load_val = w_cur.read ? mem_rdata : '0;
  assign w_new_val  = w_abort ? '0 : w_load_val;
  assign w_wr0 = (r_state == ST_ACC0) & (w_commit | w_abort);
  assign w_wr1 = (r_state == ST_ACC1) & (w_commit | w_abort);

  mem_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (~w_in_acc | mem_ready | w_expire),
    .i_en     (w_in_acc & ~mem_ready),
    .o_expire (w_expire)
  );

  always_comb begin
    w_nxt        = r_state;
    stall_req    = 1'b0;
    done         = 1'b0;
    mem_req      = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_width    = 2'b00;
    mem_unsigned = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_pc       = '0;
    mem_is_inst1 = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        stall_req = bundle_valid & w_need_any & ~flush;
        done      = bundle_valid & ~w_need_any;
        if (bundle_valid && !flush) begin
          if (w_need0) begin
            w_nxt = ST_ACC0;
          end else if (w_need1) begin
            w_nxt = ST_ACC1;
          end
        end
      end
      ST_ACC0, ST_ACC1: begin
        stall_req    = 1'b1;
        mem_req      = 1'b1;
        mem_re       = w_cur.read;
        mem_we       = w_cur.write;
        mem_width    = w_cur.width;
        mem_unsigned = w_cur.is_unsigned;
        mem_addr     = w_cur.addr;
        mem_wdata    = w_cur.wdata;
        mem_pc       = w_cur.pc;
        mem_is_inst1 = (r_state == ST_ACC1);
        if (mem_ready) begin
          if (w_kill) begin
            w_nxt = ST_IDLE;
          end else if (r_state == ST_ACC0 && w_need1) begin
            w_nxt = ST_ACC1;
          end else begin
            w_nxt = ST_DONE;
          end
        end else if (w_expire) begin
          w_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (!stall_ext || flush) begin
          w_nxt = ST_IDLE;
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_flushed <= 1'b0;
      r_timeout <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_state   <= w_nxt;
      r_flushed <= w_in_acc & ~mem_ready & ~w_expire & (r_flushed | flush);
      if (w_abort) begin
        r_timeout <= 1'b1;
      end
      if (w_wr0) begin
        r_rdata0 <= w_new_val;
      end
      if (w_wr1) begin
        r_rdata1 <= w_new_val;
      end
    end
  end

  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bundle bench for mem_port_arbiter,
// checked against a transaction-level expectation of each bundle.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bundle_valid = 1'b0;
  logic          flush = 1'b0;
  logic          stall_ext = 1'b0;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  logic          mem_req, mem_re, mem_we, mem_unsigned, mem_is_inst1;
  logic [1:0]    mem_width;
  logic [DW-1:0] mem_addr, mem_wdata, rdata0, rdata1;
  logic [31:0]   mem_pc;
  logic          done, stall_req, timeout_err;

  bit          sv[2], sr[2], sw[2], su[2];
  logic [1:0]  swd[2];
  logic [31:0] sa[2], sd[2], spc[2];

  logic [31:0] m_rd[2];
  bit          m_terr;
  bit          use_fix;
  logic [31:0] rd_fix;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bundle_valid  (bundle_valid),
    .flush         (flush),
    .stall_ext     (stall_ext),
    .req0_valid    (sv[0]),
    .req0_read     (sr[0]),
    .req0_write    (sw[0]),
    .req0_width    (swd[0]),
    .req0_unsigned (su[0]),
    .req0_addr     (sa[0]),
    .req0_wdata    (sd[0]),
    .req0_pc       (spc[0]),
    .req1_valid    (sv[1]),
    .req1_read     (sr[1]),
    .req1_write    (sw[1]),
    .req1_width    (swd[1]),
    .req1_unsigned (su[1]),
    .req1_addr     (sa[1]),
    .req1_wdata    (sd[1]),
    .req1_pc       (spc[1]),
    .mem_req       (mem_req),
    .mem_re        (mem_re),
    .mem_we        (mem_we),
    .mem_width     (mem_width),
    .mem_unsigned  (mem_unsigned),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_pc        (mem_pc),
    .mem_is_inst1  (mem_is_inst1),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .rdata0        (rdata0),
    .rdata1        (rdata1),
    .done          (done),
    .stall_req     (stall_req),
    .timeout_err   (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int k, input bit v, input int op,
                          input logic [31:0] a);
    sv[k]  = v;
    sr[k]  = (op == 1);
    sw[k]  = (op == 2);
    swd[k] = 2'($urandom);
    su[k]  = 1'($urandom);
    sa[k]  = a;
    sd[k]  = $urandom;
    spc[k] = $urandom;
  endtask

  function automatic bit need(input int k);
    return sv[k] & (sr[k] | sw[k]);
  endfunction

  // One whole bundle: slot k waits wt[k] cycles before ready, DONE held by stall_ext for hold cycles.
  task automatic run_bundle(input int w0, input int w1, input int hold);
    int wt[2];
    int stalls;
    int exp_st;
    bit any;
    logic [31:0] rd;
    wt[0] = w0;
    wt[1] = w1;
    any = need(0) | need(1);
    @(negedge clk);
    bundle_valid = 1'b1;
    flush = 1'b0;
    stall_ext = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("idle_stall", 32'(stall_req), 32'(any));
    chk("idle_done", 32'(done), 32'(!any));
    chk("idle_req", 32'(mem_req), 32'(0));
    stalls = int'(stall_req);
    exp_st = any ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      if (need(k)) begin
        exp_st += wt[k] + 1;
        for (int c = 0; c <= wt[k]; c++) begin
          @(negedge clk);
          rd = use_fix ? rd_fix : $urandom;
          mem_rdata = rd;
          mem_ready = (c == wt[k]);
          #1;
          chk("acc_ctl",
              32'({mem_req, mem_re, mem_we, mem_is_inst1, mem_unsigned, mem_width}),
              32'({1'b1, sr[k], sw[k], 1'(k), su[k], swd[k]}));
          chk("acc_addr", mem_addr, sa[k]);
          chk("acc_wdata", mem_wdata, sd[k]);
          chk("acc_pc", mem_pc, spc[k]);
          stalls += int'(stall_req);
          if (c == wt[k]) m_rd[k] = sr[k] ? rd : 32'h0;
        end
      end
    end
    if (any) begin
      @(negedge clk);
      mem_ready = 1'b0;
      bundle_valid = 1'b0;
      stall_ext = (hold > 0);
      #1;
      chk("done_flags", 32'({done, stall_req, mem_req}), 32'(3'b100));
      chk("done_rd0", rdata0, m_rd[0]);
      chk("done_rd1", rdata1, m_rd[1]);
      chk("done_terr", 32'(timeout_err), 32'(m_terr));
      chk("stall_cycles", 32'(stalls), 32'(exp_st));
      for (int h = 1; h <= hold; h++) begin
        @(negedge clk);
        stall_ext = (h < hold);
        #1;
        chk("hold_done", 32'(done), 32'(1));
        chk("hold_rd0", rdata0, m_rd[0]);
        chk("hold_rd1", rdata1, m_rd[1]);
      end
    end
    @(negedge clk);
    bundle_valid = 1'b0;
    stall_ext = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("back_idle", 32'({done, stall_req, mem_req}), 32'(0));
  endtask

  initial begin
    int acc;
    logic [31:0] keep0, keep1;
    m_rd[0] = '0;
    m_rd[1] = '0;
    m_terr  = 1'b0;
    use_fix = 1'b0;
    rd_fix  = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_flags", 32'({mem_req, stall_req, done, timeout_err}), 32'(0));
    chk("rst_rd0", rdata0, 32'h0);
    chk("rst_rd1", rdata1, 32'h0);
    rst = 1'b1;

    // stray mem_ready while idle
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'h5A5A_1234;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("idle_ready_rd0", rdata0, 32'h0);
    chk("idle_ready_req", 32'(mem_req), 32'(0));

    // bundle with no memory op
    set_slot(0, 1'b1, 0, 32'h40);
    set_slot(1, 1'b0, 1, 32'h44);
    run_bundle(0, 0, 0);

    // single slot-0 load
    set_slot(0, 1'b1, 1, 32'h100);
    set_slot(1, 1'b0, 0, 32'h0);
    use_fix = 1'b1;
    rd_fix  = 32'hCAFE_0001;
    run_bundle(0, 0, 0);
    use_fix = 1'b0;
    chk("t2_rd0", rdata0, 32'hCAFE_0001);

    // store then load, zero wait
    set_slot(0, 1'b1, 2, 32'h10);
    set_slot(1, 1'b1, 1, 32'h14);
    run_bundle(0, 0, 0);

    // flush during the slot-0 store
    set_slot(0, 1'b1, 2, 32'h10);
    set_slot(1, 1'b1, 1, 32'h14);
    keep0 = rdata0;
    keep1 = rdata1;
    @(negedge clk);
    bundle_valid = 1'b1;
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fl_acc0", 32'({mem_req, mem_we, mem_is_inst1}), 32'(3'b110));
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_wait", 32'({mem_req, mem_we, mem_is_inst1}), 32'(3'b110));
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("fl_commit", 32'({mem_req, mem_we, mem_is_inst1}), 32'(3'b110));
    @(negedge clk);
    mem_ready = 1'b0;
    bundle_valid = 1'b0;
    #1;
    chk("fl_idle", 32'({mem_req, stall_req, done}), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("fl_quiet", 32'({mem_req, done}), 32'(0));
    end
    chk("fl_rd0", rdata0, keep0);
    chk("fl_rd1", rdata1, keep1);

    // randomized bundles
    for (int n = 0; n < 30; n++) begin
      set_slot(0, ($urandom % 4) != 0, int'($urandom % 3), $urandom);
      set_slot(1, ($urandom % 4) != 0, int'($urandom % 3), $urandom);
      run_bundle(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)));
    end

    // make rdata0 non-zero, then let the watchdog fire
    set_slot(0, 1'b1, 1, 32'h200);
    set_slot(1, 1'b0, 0, 32'h0);
    use_fix = 1'b1;
    rd_fix  = 32'h1234_5678;
    run_bundle(1, 0, 0);
    use_fix = 1'b0;
    @(negedge clk);
    bundle_valid = 1'b1;
    mem_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (!mem_req) break;
      acc++;
    end
    bundle_valid = 1'b0;
    m_rd[0] = 32'h0;
    m_terr  = 1'b1;
    chk("to_cycles", 32'(acc), 32'(TO));
    chk("to_done", 32'({done, stall_req}), 32'(2'b10));
    chk("to_err", 32'(timeout_err), 32'(1));
    chk("to_rd0", rdata0, 32'h0);
    @(negedge clk);
    #1;
    chk("to_idle", 32'({done, mem_req}), 32'(0));

    // DONE held by stall_ext, error flag stays sticky
    set_slot(0, 1'b1, 1, 32'h300);
    set_slot(1, 1'b1, 1, 32'h304);
    run_bundle(0, 1, 3);

    // reset while serving slot 1
    set_slot(0, 1'b1, 1, 32'h400);
    set_slot(1, 1'b1, 1, 32'h404);
    @(negedge clk);
    bundle_valid = 1'b1;
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("rs_acc1", 32'({mem_req, mem_is_inst1}), 32'(2'b11));
    rst = 1'b0;
    bundle_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rs_flags", 32'({mem_req, stall_req, done, timeout_err}), 32'(0));
    chk("rs_rd0", rdata0, 32'h0);
    chk("rs_rd1", rdata1, 32'h0);
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
